// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
//   Splits a time-division-multiplexed word stream into four parallel lanes.
//   A frame is four accepted words (slot 0..3). The slot-0 word carries sof.
//   Words are collected in shadow registers. The lanes a..d are loaded all at
//   once when the slot-3 word is accepted, so a..d only ever show whole frames.
//   Framing violations pulse sync_err and resynchronise on the next sof.
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : synchronous active-low reset
//   din         : time-multiplexed data word (WIDTH bits)
//   din_valid   : din carries a word this cycle
//   sof         : start of frame, marks the slot-0 word (qualified by din_valid)
//   a, b, c, d  : registered lanes for slots 0, 1, 2, 3
//   frame_valid : one-cycle pulse, a..d hold a newly completed frame
//   sync_err    : one-cycle pulse, framing violation detected
//   slot        : index of the next expected slot
//   frame_cnt   : completed frame count, modulo 256
// -----------------------------------------------------------------------------
module tdm_demux_1to4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic             sync_err,
    output logic [1:0]       slot,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned SLOT_W = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Framing state
    state_t              r_state;
    state_t              w_state_nxt;
    logic [SLOT_W-1:0]   r_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;

    // Shadow registers for slots 0..2; slot 3 goes straight from din to d
    logic [WIDTH-1:0]    r_sh0;
    logic [WIDTH-1:0]    r_sh1;
    logic [WIDTH-1:0]    r_sh2;
    logic [2:0]          w_sh_we;

    // Per-cycle decisions
    logic                w_load;
    logic                w_err;

    // Registered outputs
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_c;
    logic [WIDTH-1:0]    r_d;
    logic                r_frame_valid;
    logic                r_sync_err;
    logic [CNT_W-1:0]    r_frame_cnt;

    // State register; reset wins over any word on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
            r_slot  <= SLOT_W'(0);
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    // Next-state, shadow write enables and frame/error decisions
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_sh_we     = 3'b000;
        w_load      = 1'b0;
        w_err       = 1'b0;

        if (din_valid) begin
            unique case (r_state)
                ST_HUNT: begin
                    // Non-sof words are silently dropped while hunting
                    if (sof) begin
                        w_sh_we     = 3'b001;
                        w_slot_nxt  = SLOT_W'(1);
                        w_state_nxt = ST_RECV;
                    end else begin
                        w_slot_nxt  = SLOT_W'(0);
                    end
                end

                ST_RECV: begin
                    if (r_slot == SLOT_W'(0)) begin
                        if (sof) begin
                            // Back-to-back frame start
                            w_sh_we    = 3'b001;
                            w_slot_nxt = SLOT_W'(1);
                        end else begin
                            // Expected a frame start but got none: lose lock
                            w_err       = 1'b1;
                            w_state_nxt = ST_HUNT;
                            w_slot_nxt  = SLOT_W'(0);
                        end
                    end else if (sof) begin
                        // Early sof: drop partial frame, restart on this word
                        w_err      = 1'b1;
                        w_sh_we    = 3'b001;
                        w_slot_nxt = SLOT_W'(1);
                    end else if (r_slot == SLOT_W'(3)) begin
                        w_load     = 1'b1;
                        w_slot_nxt = SLOT_W'(0);
                    end else begin
                        w_sh_we    = (r_slot == SLOT_W'(1)) ? 3'b010 : 3'b100;
                        w_slot_nxt = r_slot + SLOT_W'(1);
                    end
                end

                default: begin
                    w_state_nxt = ST_HUNT;
                    w_slot_nxt  = SLOT_W'(0);
                end
            endcase
        end
    end

    // Shadow storage; never reaches a..d without a full frame, so no reset
    always_ff @(posedge clk) begin
        if (w_sh_we[0]) r_sh0 <= din;
        if (w_sh_we[1]) r_sh1 <= din;
        if (w_sh_we[2]) r_sh2 <= din;
    end

    // Output lanes, pulses and frame counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_cnt   <= CNT_W'(0);
        end else begin
            r_frame_valid <= w_load;
            r_sync_err    <= w_err;
            if (w_load) begin
                r_a         <= r_sh0;
                r_b         <= r_sh1;
                r_c         <= r_sh2;
                r_d         <= din;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign c           = r_c;
    assign d           = r_d;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign slot        = r_slot;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1to4
//   Directed stimulus for tdm_demux_1to4. The stimulus process pushes expected
//   frames and expected sync errors into a scoreboard. A monitor on the falling
//   edge pops and compares whenever frame_valid or sync_err is presented.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1to4;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             sof = 1'b0;
    logic [WIDTH-1:0] a, b, c, d;
    logic             frame_valid, sync_err;
    logic [1:0]       slot;
    logic [7:0]       frame_cnt;

    tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .slot        (slot),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] fa;
        logic [WIDTH-1:0] fb;
        logic [WIDTH-1:0] fc;
        logic [WIDTH-1:0] fd;
        logic [7:0]       cnt;
    } frame_t;

    frame_t     exp_q[$];
    int         err_pending = 0;
    logic [7:0] exp_cnt = 8'd0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_fv = -1;
    bit         b2b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        frame_t f;
        cyc++;
        if (frame_valid || sync_err)
            chk("fv_err_exclusive", 32'(frame_valid & sync_err), 32'd0);
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame_valid", 32'(frame_valid), 32'd0);
            end else begin
                f = exp_q.pop_front();
                chk("frame_a", 32'(a), 32'(f.fa));
                chk("frame_b", 32'(b), 32'(f.fb));
                chk("frame_c", 32'(c), 32'(f.fc));
                chk("frame_d", 32'(d), 32'(f.fd));
                chk("frame_cnt", 32'(frame_cnt), 32'(f.cnt));
            end
            if (b2b && last_fv >= 0)
                chk("fv_spacing", 32'(cyc - last_fv), 32'd4);
            last_fv = cyc;
        end
        if (sync_err) begin
            if (err_pending == 0)
                chk("unexpected_sync_err", 32'(sync_err), 32'd0);
            else
                err_pending--;
        end
    end

    task automatic word(input logic s, input logic [WIDTH-1:0] w);
        @(negedge clk);
        din_valid = 1'b1;
        sof       = s;
        din       = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            sof       = 1'($urandom);
            din       = WIDTH'($urandom);
        end
    endtask

    task automatic exp_frame(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                             input logic [WIDTH-1:0] ec, input logic [WIDTH-1:0] ed);
        frame_t f;
        exp_cnt = exp_cnt + 8'd1;
        f.fa = ea; f.fb = eb; f.fc = ec; f.fd = ed; f.cnt = exp_cnt;
        exp_q.push_back(f);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a"}, 32'(a), 32'd0);
        chk({tag, "_b"}, 32'(b), 32'd0);
        chk({tag, "_c"}, 32'(c), 32'd0);
        chk({tag, "_d"}, 32'(d), 32'd0);
        chk({tag, "_fv"}, 32'(frame_valid), 32'd0);
        chk({tag, "_err"}, 32'(sync_err), 32'd0);
        chk({tag, "_slot"}, 32'(slot), 32'd0);
        chk({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    // Reset held with a sof word present; reset must win
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b1;
        sof       = 1'b1;
        din       = 4'hF;
        @(negedge clk);
        check_all_zero(tag);
        rst_n     = 1'b1;
        din_valid = 1'b0;
        sof       = 1'b0;
        exp_cnt   = 8'd0;
    endtask

    initial begin
        // Reset state and reset priority
        do_reset("reset");

        // Basic frame
        exp_frame(4'h4, 4'hA, 4'h3, 4'hC);
        word(1'b1, 4'h4);
        word(1'b0, 4'hA);
        chk("basic_slot1", 32'(slot), 32'd1);
        word(1'b0, 4'h3);
        word(1'b0, 4'hC);
        chk("basic_slot3", 32'(slot), 32'd3);
        idle(1);
        chk("basic_cnt", 32'(frame_cnt), 32'd1);
        chk("basic_slot0", 32'(slot), 32'd0);
        idle(1);
        chk("basic_fv_one_cycle", 32'(frame_valid), 32'd0);

        // Hunt: leading non-sof words are discarded quietly
        // (RECV at slot 0 first needs a sof; go to HUNT via a forced error)
        err_pending++;
        word(1'b0, 4'hF);
        word(1'b0, 4'h1);
        chk("hunt_slot", 32'(slot), 32'd0);
        exp_frame(4'h1, 4'h2, 4'h4, 4'h8);
        word(1'b1, 4'h1);
        word(1'b0, 4'h2);
        word(1'b0, 4'h4);
        word(1'b0, 4'h8);
        idle(1);

        // Gapped frame: lanes hold the previous frame until the 4th word
        exp_frame(4'h4, 4'hA, 4'h3, 4'hC);
        word(1'b1, 4'h4);
        idle(2);
        word(1'b0, 4'hA);
        idle(2);
        word(1'b0, 4'h3);
        idle(2);
        chk("gap_slot3", 32'(slot), 32'd3);
        chk("gap_hold_a", 32'(a), 32'h1);
        chk("gap_hold_d", 32'(d), 32'h8);
        word(1'b0, 4'hC);
        idle(1);

        // Early sof on the 3rd word resynchronises
        word(1'b1, 4'h5);
        word(1'b0, 4'h6);
        err_pending++;
        word(1'b1, 4'h7);
        word(1'b0, 4'h8);
        chk("resync_slot1", 32'(slot), 32'd1);
        chk("resync_hold_a", 32'(a), 32'h4);
        exp_frame(4'h7, 4'h8, 4'h9, 4'hB);
        word(1'b0, 4'h9);
        word(1'b0, 4'hB);
        idle(1);

        // Missing sof at slot 0 drops to HUNT
        err_pending++;
        word(1'b0, 4'h3);
        word(1'b0, 4'h4);
        chk("nosof_slot", 32'(slot), 32'd0);
        exp_frame(4'h9, 4'h8, 4'h7, 4'h6);
        word(1'b1, 4'h9);
        word(1'b0, 4'h8);
        word(1'b0, 4'h7);
        word(1'b0, 4'h6);
        idle(2);

        // Reset mid-frame
        word(1'b1, 4'h1);
        word(1'b0, 4'h2);
        do_reset("midreset");
        exp_frame(4'h3, 4'h5, 4'h7, 4'h9);
        word(1'b1, 4'h3);
        word(1'b0, 4'h5);
        word(1'b0, 4'h7);
        word(1'b0, 4'h9);
        idle(2);

        // 257 back-to-back frames from a fresh reset, counter wraps to 1
        do_reset("b2b_reset");
        last_fv = -1;
        b2b     = 1'b1;
        for (int i = 0; i < 257; i++) begin
            exp_frame(WIDTH'(i), WIDTH'(i + 1), WIDTH'(i + 2), WIDTH'(i + 3));
            word(1'b1, WIDTH'(i));
            word(1'b0, WIDTH'(i + 1));
            word(1'b0, WIDTH'(i + 2));
            word(1'b0, WIDTH'(i + 3));
        end
        idle(2);
        b2b = 1'b0;
        chk("wrap_cnt", 32'(frame_cnt), 32'd1);

        idle(3);
        chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
        chk("errors_outstanding", 32'(err_pending), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1to4.md
TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 Parameter: WIDTH, default 4, lane data width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: din  input  WIDTH  time-multiplexed data word.
REQ-005 Port: din_valid  input  1  din carries a word this cycle.
REQ-006 Port: sof  input  1  start-of-frame; marks the slot-0 word; qualified by din_valid.
REQ-007 Port: a, b, c, d  output  WIDTH each  registered lanes for slots 0, 1, 2, 3.
REQ-008 Port: frame_valid  output  1  one-cycle pulse; a..d hold a new complete frame.
REQ-009 Port: sync_err  output  1  one-cycle pulse; framing violation detected.
REQ-010 Port: slot  output  2  index of the next expected slot.
REQ-011 Port: frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-012 The FSM SHALL have two states, HUNT and RECV.
REQ-013 In HUNT, din_valid=1 with sof=0 SHALL be discarded without asserting sync_err.
REQ-014 HUNT transition: din_valid=1 with sof=1 SHALL store din in shadow slot 0, set slot=1 and enter RECV.
REQ-015 In RECV, din_valid=1 with slot=1..3 and sof=0 SHALL store din in shadow[slot] and increment slot.
REQ-016 Frame completion: accepting the slot-3 word SHALL load a,b,c from shadow 0..2 and d from din on that same edge.
REQ-017 The completion edge SHALL also assert frame_valid for exactly the following cycle, increment frame_cnt and set slot=0.
REQ-018 Latency: a..d SHALL be valid one cycle after the slot-3 word is sampled; 4 valid words give a minimum of 4 cycles from the first word.
REQ-019 a..d SHALL change only on frame completion or reset, and SHALL hold all other times.
REQ-020 After completion, RECV with slot=0 SHALL accept din_valid=1 with sof=1 as slot 0 of the next frame (back-to-back frames, no idle cycle).
REQ-021 RECV, slot=0, din_valid=1, sof=0: pulse sync_err, discard the word, enter HUNT, keep slot=0.
REQ-022 RECV, slot=1..3, din_valid=1, sof=1: pulse sync_err and drop the partial frame with no a..d update.
REQ-023 In that case (REQ-022), the sof word SHALL be stored as slot 0, with slot=1 and the FSM remaining in RECV.
REQ-024 din_valid=0 SHALL hold slot, shadow and state; sof with din_valid=0 SHALL be ignored.
REQ-025 frame_cnt SHALL wrap from 255 to 0 without any flag.
REQ-026 Gaps of any length between words within a frame SHALL be tolerated; there is no timeout.
REQ-027 frame_valid and sync_err SHALL never assert in the same cycle.

Reset
REQ-028 rst_n=0 at a rising edge SHALL set a=b=c=d=0, frame_valid=0, sync_err=0, slot=0, frame_cnt=0 and state=HUNT.
REQ-029 Reset mid-frame SHALL discard the partial frame, leave a..d at 0 and produce no frame_valid.
REQ-030 Reset SHALL take priority over any din_valid/sof on the same edge.
REQ-031 Shadow registers need no reset, since a..d are never loaded from them without a full frame.

Verification
REQ-032 Basic frame: release reset, then 0100(sof),1010,0011,1100 on consecutive cycles -> a=0100, b=1010, c=0011, d=1100; frame_valid for 1 cycle; frame_cnt=1.
REQ-033 Gapped frame: same words with din_valid=0 for 2 cycles between each -> identical outputs; a..d unchanged until the 4th word.
REQ-034 Hunt: words 1111,0001 without sof, then frame 0001(sof),0010,0100,1000 -> no sync_err; a..d=0001,0010,0100,1000.
REQ-035 Resync and missing sof:
- sof on the 3rd word of a frame -> sync_err pulse, then that word and the next three form the frame;
- slot-0 word without sof -> sync_err, state HUNT.
REQ-036 Back-to-back frames: 257 back-to-back frames -> frame_valid every 4th cycle, frame_cnt=1 after the wrap.
REQ-037 Reset mid-frame: rst_n low after 2 words -> all outputs 0; a following full frame decodes correctly.
